// File: rtl/dht11_sensor_model.sv
// Sensor end of the single-wire DHT11 link: detects the host start pulse and
// answers with the response preamble plus a 40-bit humidity/temperature frame.
module dht11_sensor_model #(
  parameter int unsigned CLK_PER_US    = 50,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned PRE_LOW_US    = 80,
  parameter int unsigned PRE_HIGH_US   = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 27,
  parameter int unsigned BIT1_HIGH_US  = 70
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dht_in,
  output logic       dht_drive_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       present,
  input  logic       corrupt_chk,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned START_CYC = START_MIN_US * CLK_PER_US;
  localparam int unsigned RESP_CYC  = RESP_DELAY_US * CLK_PER_US;
  localparam int unsigned PLOW_CYC  = PRE_LOW_US * CLK_PER_US;
  localparam int unsigned PHIGH_CYC = PRE_HIGH_US * CLK_PER_US;
  localparam int unsigned BLOW_CYC  = BIT_LOW_US * CLK_PER_US;
  localparam int unsigned B0_CYC    = BIT0_HIGH_US * CLK_PER_US;
  localparam int unsigned B1_CYC    = BIT1_HIGH_US * CLK_PER_US;
  localparam int unsigned FRAME_W   = 40;

  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_REL, RESP_DLY, PRE_LOW, PRE_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t               state;
  logic [1:0]           sync_q;
  logic                 line;
  logic [31:0]          cnt;
  logic [5:0]           bit_cnt;
  logic [FRAME_W-1:0]   shreg;
  logic                 seen_high;
  logic [31:0]          phase_len_c;
  logic                 phase_end_c;
  logic [7:0]           sum_c;

  assign line  = sync_q[1];
  assign sum_c = hum_int + hum_dec + temp_int + temp_dec;

  // Length in cycles of the phase the current state is timing.
  always_comb begin
    phase_len_c = 32'd1;
    case (state)
      START_LOW: phase_len_c = START_CYC;
      RESP_DLY:  phase_len_c = RESP_CYC;
      PRE_LOW:   phase_len_c = PLOW_CYC;
      PRE_HIGH:  phase_len_c = PHIGH_CYC;
      BIT_LOW:   phase_len_c = BLOW_CYC;
      BIT_HIGH:  phase_len_c = shreg[FRAME_W-1] ? B1_CYC : B0_CYC;
      END_LOW:   phase_len_c = BLOW_CYC;
      default:   phase_len_c = 32'd1;
    endcase
  end

  assign phase_end_c = (cnt == phase_len_c - 32'd1);

  // Protocol sequencer; cnt restarts from zero on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sync_q        <= 2'b11;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      seen_high     <= 1'b0;
      dht_drive_low <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], dht_in};
      frame_done <= 1'b0;
      cnt        <= cnt + 32'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (line) begin
            seen_high <= 1'b1;
          end else if (present && seen_high) begin
            seen_high <= 1'b0;
            state     <= START_LOW;
          end
        end
        START_LOW: begin
          if (line) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (phase_end_c) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          cnt <= '0;
          if (line) begin
            shreg <= {hum_int, hum_dec, temp_int, temp_dec,
                      sum_c[7:1], sum_c[0] ^ corrupt_chk};
            state <= RESP_DLY;
          end
        end
        RESP_DLY: begin
          if (phase_end_c) begin
            cnt           <= '0;
            dht_drive_low <= 1'b1;
            state         <= PRE_LOW;
          end
        end
        PRE_LOW: begin
          if (phase_end_c) begin
            cnt           <= '0;
            dht_drive_low <= 1'b0;
            state         <= PRE_HIGH;
          end
        end
        PRE_HIGH: begin
          if (phase_end_c) begin
            cnt           <= '0;
            bit_cnt       <= '0;
            dht_drive_low <= 1'b1;
            state         <= BIT_LOW;
          end
        end
        BIT_LOW: begin
          if (phase_end_c) begin
            cnt           <= '0;
            dht_drive_low <= 1'b0;
            state         <= BIT_HIGH;
          end
        end
        BIT_HIGH: begin
          if (phase_end_c) begin
            cnt           <= '0;
            shreg         <= {shreg[FRAME_W-2:0], 1'b0};
            dht_drive_low <= 1'b1;
            if (bit_cnt == 6'd39) begin
              state <= END_LOW;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              state   <= BIT_LOW;
            end
          end
        end
        END_LOW: begin
          if (phase_end_c) begin
            cnt           <= '0;
            dht_drive_low <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          cnt           <= '0;
          dht_drive_low <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
